// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with word-by-word line refill.
// Latency: a hit answers combinationally in the same cycle. A miss costs 1 cycle plus WORDS x memory latency.
// Backpressure: icache_data_ready_o stays low during a miss. The refill holds mem_en_o high until the last word.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   icache_en_i            fetch request
//   iphy_addr_i            physical fetch address (bits [1:0] ignored)
//   icache_flush_i         one-cycle pulse that invalidates every line
//   icache_data_o          fetched word, valid while icache_data_ready_o is high (0 otherwise)
//   icache_data_ready_o    hit for the current request
//   mem_en_o, mem_addr_o   refill word-read request and word address
//   mem_data_i             refill read data
//   mem_data_ready_i       refill read data valid this cycle
//   hit_count_o, miss_count_o  statistics outputs, present only when ICACHE_STATS_EN is defined
// Optional feature macro: ICACHE_STATS_EN

module icache_direct #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_en_i,
  input  logic [31:0] iphy_addr_i,
  input  logic        icache_flush_i,
  output logic [31:0] icache_data_o,
  output logic        icache_data_ready_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_data_ready_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_e;

  state_e                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_BITS-1:0]      refill_tag_q, refill_tag_d;
  logic [INDEX_BITS-1:0]    refill_idx_q, refill_idx_d;
  logic [OFFSET_BITS-1:0]   wcnt_q, wcnt_d;

  // Tag and data arrays: asynchronous read and no reset. The valid bits alone qualify their contents.
  logic [TAG_BITS-1:0]      tag_mem  [LINES];
  logic [31:0]              data_mem [LINES*WORDS];
  logic                     data_we;
  logic                     tag_we;

  logic [OFFSET_BITS-1:0]   addr_off;
  logic [INDEX_BITS-1:0]    addr_idx;
  logic [TAG_BITS-1:0]      addr_tag;
  logic                     hit;
  logic                     miss_start;
  logic                     unused_addr_lsb;

  assign addr_off        = iphy_addr_i[OFFSET_BITS+1:2];
  assign addr_idx        = iphy_addr_i[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign addr_tag        = iphy_addr_i[31:INDEX_BITS+OFFSET_BITS+2];
  assign unused_addr_lsb = ^iphy_addr_i[1:0];

  // Lookups are only answered in IDLE. During a refill, ready stays low even when the requested word has already landed.
  assign hit = icache_en_i && (state_q == S_IDLE) && valid_q[addr_idx] &&
               (tag_mem[addr_idx] == addr_tag);

  assign icache_data_ready_o = hit;
  assign icache_data_o       = hit ? data_mem[{addr_idx, addr_off}] : 32'd0;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    refill_tag_d = refill_tag_q;
    refill_idx_d = refill_idx_q;
    wcnt_d       = wcnt_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    miss_start   = 1'b0;
    mem_en_o     = 1'b0;
    mem_addr_o   = 32'd0;

    // A flush is applied first. A refill that completes in the same cycle then re-marks its own line valid,
    // because that line's data comes straight from memory.
    if (icache_flush_i) begin
      valid_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (icache_en_i && !hit) begin
          refill_tag_d      = addr_tag;
          refill_idx_d      = addr_idx;
          wcnt_d            = '0;
          valid_d[addr_idx] = 1'b0;
          miss_start        = 1'b1;
          state_d           = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_en_o   = 1'b1;
        mem_addr_o = {refill_tag_q, refill_idx_q, wcnt_q, 2'b00};
        if (mem_data_ready_i) begin
          data_we = 1'b1;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == {OFFSET_BITS{1'b1}}) begin
            valid_d[refill_idx_q] = 1'b1;
            tag_we                = 1'b1;
            state_d               = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      refill_tag_q <= '0;
      refill_idx_q <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      refill_tag_q <= refill_tag_d;
      refill_idx_q <= refill_idx_d;
      wcnt_q       <= wcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_mem[{refill_idx_q, wcnt_q}] <= mem_data_i;
    end
    if (tag_we) begin
      tag_mem[refill_idx_q] <= refill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Both counters wrap naturally. A flush does not clear them.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache sitting directly downstream of the MMU's instruction path. It receives `iphy_addr`/`icache_en` from the MMU, returns `icache_data`/`icache_data_ready`, and refills missing lines word by word from the memory bus. A hit answers combinationally in the same cycle. A miss stalls the core through a low ready until the line is filled.

## Interface

Parameters:
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS.
- `OFFSET_BITS`, default 2: words per line is 2^OFFSET_BITS.

Ports:
- `clk_i`  in  1  clock. All state updates on the rising edge.
- `rst_i`  in  1  reset. Asynchronous, active-low.
- `icache_en_i`  in  1  fetch request from the MMU (kseg0 cached, or mapped-cached).
- `iphy_addr_i`  in  32  physical fetch address. Bits [1:0] are ignored.
- `icache_flush_i`  in  1  one-cycle pulse that invalidates all lines.
- `icache_data_o`  out  32  instruction word. Valid when ready is high.
- `icache_data_ready_o`  out  1  hit indication for the current request.
- `mem_en_o`  out  1  memory bus word-read request.
- `mem_addr_o`  out  32  word address of the refill read.
- `mem_data_i`  in  32  memory read data.
- `mem_data_ready_i`  in  1  memory read data is valid this cycle.

## Operation

- Address split:
  - offset = `iphy_addr_i[OFFSET_BITS+1:2]`
  - index = next INDEX_BITS bits
  - tag = `iphy_addr_i[31:INDEX_BITS+OFFSET_BITS+2]`
- Storage:
  - valid bit per line.
  - tag register array and data register array, both with asynchronous read.
- hit = `icache_en_i` & state==IDLE & valid[index] & tag match.
- `icache_data_o` = data[index][offset] when hit, else 0.
- `icache_data_ready_o` = hit.
- FSM:
  - IDLE: if `icache_en_i` and not hit, latch tag/index into `refill_tag`/`refill_idx`, clear word counter `wcnt`, clear valid[index], go to REFILL.
  - REFILL: `mem_en_o`=1, `mem_addr_o`={refill_tag, refill_idx, wcnt, 2'b00}.
    - On `mem_data_ready_i`: write `mem_data_i` to data[refill_idx][wcnt] and increment `wcnt`.
    - When the last word (wcnt = all ones) is accepted: set valid[refill_idx]=1, write tag, go to IDLE.
    - `mem_en_o` stays high continuously until the final ready.
- A refill always completes, even if `icache_en_i` drops or the address changes mid-refill.
- After returning to IDLE, a new lookup is made against the current address.
- Flush:
  - Clears every valid bit at the clock edge.
  - If a flush arrives during REFILL, the refill continues and its line is marked valid at the end, because the data is fresh from memory.
  - If the flush and the final refill word land in the same cycle, the refilled line ends valid and all others invalid.
- The block is read-only. There are no writes from the core, and self-modifying code requires a flush.

## Timing

- Reset values:
  - state=IDLE, all valid bits=0, `wcnt`=0.
  - `mem_en_o`=0, `mem_addr_o`=0.
  - `icache_data_ready_o`=0, `icache_data_o`=0.
- Hit latency: 0 cycles. Ready is combinational from the address in IDLE.
- Miss penalty, with memory latency L cycles per word:
  - 1 cycle (IDLE→REFILL edge), plus 2^OFFSET_BITS×L cycles of refill.
  - Then ready goes high in the first IDLE cycle.
  - With L=1 and 4 words, a miss first seen in cycle 0 returns a hit in cycle 5.
- `mem_data_ready_i` is ignored outside REFILL.
- Asserting reset mid-refill aborts immediately: `mem_en_o` drops asynchronously and all lines are invalid.
- Ready is 0 throughout REFILL, including when the requested word has already been written.

## Configuration

- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count_o[31:0]` and `miss_count_o[31:0]`, both reset to 0 and wrapping at 2^32.
  - `hit_count_o` increments on every cycle with hit=1.
  - `miss_count_o` increments on every IDLE→REFILL transition.
  - A flush does not clear the counters.
- Macro undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan

- Cold miss:
  - Stimulus: after reset, en=1, addr=0x0000_1004, memory returns 0xA0+word with L=1.
  - Required: `mem_addr_o` steps 0x1000, 0x1004, 0x1008, 0x100C; ready first high in cycle 5 with data 0xA1.
- Line hit: after the cold miss, addresses 0x1000, 0x1008, 0x100C each give ready=1 in the same cycle, with data 0xA0, 0xA2, 0xA3, and `mem_en_o` stays 0.
- Conflict: after 0x1000 is filled, fetch 0x2000 (same index, different tag).
  - Required: refill of 0x2000–0x200C.
  - A following fetch of 0x1000 misses again (`miss_count_o`=3 with stats enabled).
- Flush mid-refill: pulse flush during the 2nd refill word.
  - Required: the refill finishes, its line hits afterwards, and a previously valid other line misses.
- Slow memory, address change: L=3 and `icache_en_i` dropped mid-refill.
  - Required: `mem_en_o` stays high until the 4th ready, and ready=0 throughout.
- Reset mid-refill: assert `rst_i` low during REFILL.
  - Required: `mem_en_o`=0 immediately, and after release a fetch to the same address misses.
